// File: rtl/kugelblitz_pkg.sv
// Shared types and reset constants for the kugelblitz byte-rewrite stream block.
package kugelblitz_pkg;

  localparam int unsigned RULE_OFFSET_W = 16;

  typedef struct packed {
    logic [RULE_OFFSET_W-1:0] offset;
    logic [7:0]               value;
    logic                     enable;
  } rule_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  localparam rule_t  RULE_RESET  = '{offset: '0, value: '0, enable: 1'b0};
  localparam state_t STATE_RESET = ST_IDLE;

  // Width of a rule index bus; a single rule still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kugelblitz_rewrite_if.sv
// AXI-stream style bundle used between the rewrite logic and the skid/output stage.
interface kugelblitz_rewrite_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/kugelblitz_axis_skid.sv
// One-entry skid buffer feeding a registered output stage; upstream ready is a flop.
module kugelblitz_axis_skid
  import kugelblitz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  kugelblitz_rewrite_if.slave  s,
  kugelblitz_rewrite_if.master m
);

  localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  logic [PW-1:0] in_c;
  logic [PW-1:0] out_q;
  logic [PW-1:0] skid_q;
  logic          out_valid;
  logic          skid_valid;
  logic          ready;
  logic          in_fire_c;
  logic          out_free_c;

  assign in_c       = {s.tuser, s.tlast, s.tkeep, s.tdata};
  assign in_fire_c  = s.tvalid & ready;
  assign out_free_c = ~out_valid | m.tready;

  assign s.tready = ready;
  assign m.tvalid = out_valid;
  assign {m.tuser, m.tlast, m.tkeep, m.tdata} = out_q;

  // Ready drops only once the skid slot is occupied, so a beat is never refused
  // while there is room and never lost when the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready      <= 1'b0;
    end else if (out_free_c) begin
      ready <= 1'b1;
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire_c) begin
        out_q     <= in_c;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire_c) begin
      skid_q     <= in_c;
      skid_valid <= 1'b1;
      ready      <= 1'b0;
    end else begin
      ready <= ~skid_valid;
    end
  end

endmodule

// File: rtl/kugelblitz_rewrite.sv
// Stream byte-rewrite engine: per-frame rule snapshot, byte overwrite, one-cycle output stage.
// Statistics counters are built only when KUGELBLITZ_REWRITE_STATS_EN is defined.
module kugelblitz_rewrite
  import kugelblitz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned RULE_COUNT   = 4,
  parameter int unsigned OFFSET_WIDTH = 11,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]              s_axis_tkeep,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,
  input  logic [USER_WIDTH-1:0]              s_axis_tuser,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [USER_WIDTH-1:0]              m_axis_tuser,
  input  logic                               cfg_we,
  input  logic [idx_width(RULE_COUNT)-1:0]   cfg_idx,
  input  logic [OFFSET_WIDTH-1:0]            cfg_offset,
  input  logic [7:0]                         cfg_value,
  input  logic                               cfg_enable,
  output logic [CNT_WIDTH-1:0]               stat_frames,
  output logic [CNT_WIDTH-1:0]               stat_hits
);

  localparam int unsigned IDX_W  = idx_width(RULE_COUNT);
  localparam int unsigned BEAT_W = OFFSET_WIDTH;
  localparam logic [BEAT_W-1:0] BEAT_SAT = '1;

  rule_t             rules     [RULE_COUNT];
  rule_t             active    [RULE_COUNT];
  rule_t             cur_rules [RULE_COUNT];
  state_t            state;
  logic [BEAT_W-1:0] beat_idx;
  logic [BEAT_W-1:0] cur_idx_c;
  logic              frame_hit;
  logic              frame_hit_c;
  logic              beat_hit_c;
  logic              in_fire_c;
  logic [DATA_WIDTH-1:0] rw_data_c;

  kugelblitz_rewrite_if #(
    .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH), .USER_WIDTH(USER_WIDTH + 1)
  ) rw_if ();

  kugelblitz_rewrite_if #(
    .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH), .USER_WIDTH(USER_WIDTH + 1)
  ) out_if ();

  // Rule table; indices with no matching entry are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < RULE_COUNT; r++) rules[r] <= RULE_RESET;
    end else if (cfg_we) begin
      for (int r = 0; r < RULE_COUNT; r++) begin
        if (cfg_idx == IDX_W'(r)) begin
          rules[r] <= '{offset: RULE_OFFSET_W'(cfg_offset), value: cfg_value, enable: cfg_enable};
        end
      end
    end
  end

  assign in_fire_c = s_axis_tvalid & rw_if.tready;

  // A frame's first beat sees the live table (pre-write); later beats use the snapshot.
  always_comb begin
    cur_idx_c = (state == ST_IDLE) ? '0 : beat_idx;
    for (int r = 0; r < RULE_COUNT; r++) begin
      cur_rules[r] = (state == ST_IDLE) ? rules[r] : active[r];
    end
  end

  // Byte replace; iterating high-to-low lets the lowest matching rule win.
  always_comb begin
    rw_data_c  = '0;
    beat_hit_c = 1'b0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      if (s_axis_tkeep[k]) begin
        rw_data_c[8*k +: 8] = s_axis_tdata[8*k +: 8];
        if (cur_idx_c != BEAT_SAT) begin
          for (int r = RULE_COUNT - 1; r >= 0; r--) begin
            if (cur_rules[r].enable &&
                (32'(cur_rules[r].offset) == 32'(cur_idx_c) * 32'(KEEP_WIDTH) + 32'(k))) begin
              rw_data_c[8*k +: 8] = cur_rules[r].value;
              beat_hit_c          = 1'b1;
            end
          end
        end
      end
    end
  end

  assign frame_hit_c = frame_hit | beat_hit_c;

  // Frame tracking: state, saturating beat index, rule snapshot and frame hit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STATE_RESET;
      beat_idx  <= '0;
      frame_hit <= 1'b0;
      for (int r = 0; r < RULE_COUNT; r++) active[r] <= RULE_RESET;
    end else if (in_fire_c) begin
      if (state == ST_IDLE) begin
        for (int r = 0; r < RULE_COUNT; r++) active[r] <= rules[r];
      end
      if (s_axis_tlast) begin
        state     <= ST_IDLE;
        beat_idx  <= '0;
        frame_hit <= 1'b0;
      end else begin
        state     <= ST_FRAME;
        beat_idx  <= (cur_idx_c == BEAT_SAT) ? cur_idx_c : cur_idx_c + BEAT_W'(1);
        frame_hit <= frame_hit_c;
      end
    end
  end

  // The frame hit flag rides as an extra tuser bit so it reaches the output with tlast.
  assign rw_if.tdata   = rw_data_c;
  assign rw_if.tkeep   = s_axis_tkeep;
  assign rw_if.tvalid  = s_axis_tvalid;
  assign rw_if.tlast   = s_axis_tlast;
  assign rw_if.tuser   = {frame_hit_c, s_axis_tuser};
  assign s_axis_tready = rw_if.tready;

  kugelblitz_axis_skid #(
    .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH), .USER_WIDTH(USER_WIDTH + 1)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (rw_if.slave),
    .m     (out_if.master)
  );

  assign m_axis_tdata  = out_if.tdata;
  assign m_axis_tkeep  = out_if.tkeep;
  assign m_axis_tvalid = out_if.tvalid;
  assign m_axis_tlast  = out_if.tlast;
  assign m_axis_tuser  = out_if.tuser[USER_WIDTH-1:0];
  assign out_if.tready = m_axis_tready;

`ifdef KUGELBLITZ_REWRITE_STATS_EN
  logic [CNT_WIDTH-1:0] frames_q;
  logic [CNT_WIDTH-1:0] hits_q;

  // Counted at the output handshake of each last beat; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      hits_q   <= '0;
    end else if (out_if.tvalid && m_axis_tready && out_if.tlast) begin
      frames_q <= frames_q + CNT_WIDTH'(1);
      if (out_if.tuser[USER_WIDTH]) hits_q <= hits_q + CNT_WIDTH'(1);
    end
  end

  assign stat_frames = frames_q;
  assign stat_hits   = hits_q;
`else
  logic stat_unused;
  assign stat_unused = out_if.tuser[USER_WIDTH];
  assign stat_frames = '0;
  assign stat_hits   = '0;
`endif

endmodule

// File: tb/tb_kugelblitz_rewrite.sv
// Self-checking bench for kugelblitz_rewrite: directed rule cases, random stream, reset mid-frame.
module tb_kugelblitz_rewrite;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned UW = 1;
  localparam int unsigned RC = 4;
  localparam int unsigned OW = 11;
  localparam int unsigned CW = 32;
  localparam int unsigned IW = 2;
  localparam logic [KW-1:0] KEEP_ALL = '1;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [OW-1:0] cfg_offset;
  logic [7:0]    cfg_value;
  logic          cfg_enable;
  logic [CW-1:0] stat_frames;
  logic [CW-1:0] stat_hits;
  bit            rand_mode = 1'b0;

  kugelblitz_rewrite_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_bus ();
  kugelblitz_rewrite_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_bus ();

  always #5 clk = ~clk;

  kugelblitz_rewrite dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_bus.tdata), .s_axis_tkeep(s_bus.tkeep), .s_axis_tvalid(s_bus.tvalid),
    .s_axis_tready(s_bus.tready), .s_axis_tlast(s_bus.tlast), .s_axis_tuser(s_bus.tuser),
    .m_axis_tdata(m_bus.tdata), .m_axis_tkeep(m_bus.tkeep), .m_axis_tvalid(m_bus.tvalid),
    .m_axis_tready(m_bus.tready), .m_axis_tlast(m_bus.tlast), .m_axis_tuser(m_bus.tuser),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_offset(cfg_offset), .cfg_value(cfg_value),
    .cfg_enable(cfg_enable), .stat_frames(stat_frames), .stat_hits(stat_hits)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    bit            hit;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned   m_off [RC];
  logic [7:0]    m_val [RC];
  bit            m_en  [RC];
  int unsigned   a_off [RC];
  logic [7:0]    a_val [RC];
  bit            a_en  [RC];
  bit            m_in_frame;
  int            m_beat;
  bit            m_hit;
  beat_t         exp_q [$];
  logic [DW-1:0] got_q [$];
  int            exp_frames, exp_hits, in_count, out_count;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < RC; r++) begin
      m_off[r] = 0; m_val[r] = 8'h00; m_en[r] = 1'b0;
    end
    m_in_frame = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_hits   = 0;
  endfunction

  function automatic void model_cfg();
    m_off[cfg_idx] = int'(cfg_offset);
    m_val[cfg_idx] = cfg_value;
    m_en[cfg_idx]  = cfg_enable;
  endfunction

  // Expected output for one accepted input beat: first enabled rule at this byte offset wins.
  function automatic void model_accept(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                                       input logic l, input logic [UW-1:0] u);
    beat_t b;
    if (!m_in_frame) begin
      a_off = m_off; a_val = m_val; a_en = m_en;
      m_beat = 0;
      m_hit  = 1'b0;
    end
    b.data = '0;
    for (int k = 0; k < KW; k++) begin
      if (kp[k]) begin
        b.data[8*k +: 8] = d[8*k +: 8];
        for (int r = 0; r < RC; r++) begin
          if (a_en[r] && a_off[r] == int'(m_beat * KW + k)) begin
            b.data[8*k +: 8] = a_val[r];
            m_hit = 1'b1;
            break;
          end
        end
      end
    end
    b.keep = kp; b.last = l; b.user = u; b.hit = m_hit;
    exp_q.push_back(b);
    in_count++;
    if (l) m_in_frame = 1'b0;
    else begin
      m_in_frame = 1'b1;
      m_beat++;
    end
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KW-1:0] rand_keep();
    logic [KW-1:0] kp;
    for (int i = 0; i < KW / 32; i++) kp[32*i +: 32] = $urandom;
    return kp;
  endfunction

  // Output ready pattern
  initial begin
    m_bus.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_bus.tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: beat-for-beat scoreboard, stats model and stall stability
  initial begin
    bit stall = 1'b0;
    logic [639:0] held = '0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) chk("hold", 640'({m_bus.tdata, m_bus.tkeep, m_bus.tlast, m_bus.tuser}), held);
        if (m_bus.tvalid && m_bus.tready) begin
          if (exp_q.size() == 0) chk("spurious_beat", 640'(exp_q.size()), 640'(1));
          else begin
            e = exp_q.pop_front();
            chk("beat", 640'({m_bus.tdata, m_bus.tkeep, m_bus.tlast, m_bus.tuser}),
                640'({e.data, e.keep, e.last, e.user}));
            got_q.push_back(m_bus.tdata);
            out_count++;
`ifdef KUGELBLITZ_REWRITE_STATS_EN
            if (e.last) begin
              exp_frames++;
              if (e.hit) exp_hits++;
            end
`endif
          end
        end
        stall = m_bus.tvalid && !m_bus.tready;
        held  = 640'({m_bus.tdata, m_bus.tkeep, m_bus.tlast, m_bus.tuser});
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                           input logic l, input logic [UW-1:0] u);
    int n = 0;
    s_bus.tdata = d; s_bus.tkeep = kp; s_bus.tlast = l; s_bus.tuser = u;
    s_bus.tvalid = 1'b1;
    @(negedge clk);
    while (!s_bus.tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_bus.tready) chk("in_ready_timeout", 640'(s_bus.tready), 640'(1));
    else model_accept(d, kp, l, u);
    @(posedge clk);
    #1;
    if (cfg_we) begin
      model_cfg();
      cfg_we = 1'b0;
    end
    s_bus.tvalid = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int off, input logic [7:0] val, input bit en);
    cfg_idx = IW'(idx); cfg_offset = OW'(off); cfg_value = val; cfg_enable = en;
    cfg_we = 1'b1;
    @(posedge clk);
    model_cfg();
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", 640'(exp_q.size()), 640'(0));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d0, d1, d2, mask;
    logic [KW-1:0] kp;
    int len;

    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0, d1, d2, mask;
    logic [KW-1:0] kp;
    int len;

    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_offset = '0; cfg_value = '0; cfg_enable = 1'b0;
    s_bus.tvalid = 1'b0; s_bus.tdata = '0; s_bus.tkeep = '0; s_bus.tlast = 1'b0; s_bus.tuser = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 640'(m_bus.tvalid), 640'(0));
    chk("rst_s_tready", 640'(s_bus.tready), 640'(0));
    chk("rst_stat_frames", 640'(stat_frames), 640'(0));
    chk("rst_stat_hits", 640'(stat_hits), 640'(0));
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 640'(s_bus.tready), 640'(0));
    @(posedge clk);
    #1;
    chk("ready_first_edge", 640'(s_bus.tready), 640'(1));

    // Single-beat frame, rule0 at byte 5
    cfg_write(0, 5, 8'hAA, 1'b1);
    d0 = rand_data();
    send_beat(d0, KEEP_ALL, 1'b1, 1'b1);
    chk("t1_valid_next_cycle", 640'(m_bus.tvalid), 640'(1));
    chk("t1_byte5", 640'(m_bus.tdata[47:40]), 640'(8'hAA));
    mask = '1;
    mask[47:40] = 8'h00;
    chk("t1_other_bytes", 640'(m_bus.tdata & mask), 640'(d0 & mask));
    drain();

    // Two-beat frame, rule1 at offset 70 (beat 1 byte 6)
    apply_reset();
    got_q.delete();
    cfg_write(1, 70, 8'h55, 1'b1);
    d0 = rand_data(); d1 = rand_data();
    send_beat(d0, KEEP_ALL, 1'b0, 1'b0);
    send_beat(d1, KEEP_ALL, 1'b1, 1'b0);
    drain();
    chk("t2_beat1_byte6", 640'(got_q[1][55:48]), 640'(8'h55));
    chk("t2_beat0", 640'(got_q[0]), 640'(d0));
    chk("t2_stat_frames", 640'(stat_frames), 640'(exp_frames));
    chk("t2_stat_hits", 640'(stat_hits), 640'(exp_hits));

    // Two rules on the same offset, then the byte masked off
    got_q.delete();
    cfg_write(0, 3, 8'h11, 1'b1);
    cfg_write(2, 3, 8'h22, 1'b1);
    send_beat(rand_data(), KEEP_ALL, 1'b1, 1'b0);
    kp = KEEP_ALL;
    kp[3] = 1'b0;
    send_beat(rand_data(), kp, 1'b1, 1'b1);
    drain();
    chk("t3_lowest_wins", 640'(got_q[0][31:24]), 640'(8'h11));
    chk("t3_keep0_zero", 640'(got_q[1][31:24]), 640'(8'h00));

    // Rule write mid-frame affects only the next frame (offset 130 = beat 2 byte 2)
    cfg_write(0, 130, 8'h11, 1'b1);
    got_q.delete();
    send_beat(rand_data(), KEEP_ALL, 1'b0, 1'b0);
    cfg_idx = 2'd0; cfg_offset = OW'(130); cfg_value = 8'h33; cfg_enable = 1'b1; cfg_we = 1'b1;
    send_beat(rand_data(), KEEP_ALL, 1'b0, 1'b0);
    send_beat(rand_data(), KEEP_ALL, 1'b1, 1'b0);
    drain();
    chk("t4_old_value", 640'(got_q[2][23:16]), 640'(8'h11));
    got_q.delete();
    for (int b = 0; b < 3; b++) send_beat(rand_data(), KEEP_ALL, 1'(b == 2), 1'b0);
    drain();
    chk("t4_new_value", 640'(got_q[2][23:16]), 640'(8'h33));

    // Random stream under random output backpressure
    for (int r = 0; r < RC; r++)
      cfg_write(r, int'($urandom_range(0, 255)), 8'($urandom), ($urandom % 4) != 0);
    in_count = 0;
    out_count = 0;
    rand_mode = 1'b1;
    while (in_count < 100) begin
      len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) begin
        kp = (($urandom % 4) == 0) ? rand_keep() : KEEP_ALL;
        send_beat(rand_data(), kp, 1'(b == len - 1), 1'($urandom));
        if (($urandom % 4) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_mode = 1'b0;
    drain();
    chk("t5_beat_count", 640'(out_count), 640'(in_count));
    chk("t5_stat_frames", 640'(stat_frames), 640'(exp_frames));
    chk("t5_stat_hits", 640'(stat_hits), 640'(exp_hits));

    // Reset in the middle of a frame
    cfg_write(0, 3, 8'h77, 1'b1);
    send_beat(rand_data(), KEEP_ALL, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_tvalid_in_reset", 640'(m_bus.tvalid), 640'(0));
    chk("t6_tready_in_reset", 640'(s_bus.tready), 640'(0));
    chk("t6_frames_in_reset", 640'(stat_frames), 640'(0));
    chk("t6_hits_in_reset", 640'(stat_hits), 640'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_ready_after", 640'(s_bus.tready), 640'(1));
    got_q.delete();
    d0 = rand_data(); d1 = rand_data();
    send_beat(d0, KEEP_ALL, 1'b0, 1'b0);
    send_beat(d1, KEEP_ALL, 1'b1, 1'b0);
    drain();
    chk("t6_unmodified_b0", 640'(got_q[0]), 640'(d0));
    chk("t6_unmodified_b1", 640'(got_q[1]), 640'(d1));
    chk("t6_stat_frames", 640'(stat_frames), 640'(exp_frames));
    chk("t6_stat_hits", 640'(stat_hits), 640'(exp_hits));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
